mfp_ahb_timer: RTL

//  AHB-lite slave providing a prescaled 32-bit down-counter with sticky expiry flag and

---
 rtl/mfp_ahb_timer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mfp_ahb_timer.sv
// AHB-lite timer slave: prescaled down-counter with sticky expiry flag and level IRQ.
// Zero wait states; read data is registered at the end of the address phase.
module mfp_ahb_timer #(
  parameter int COUNT_W = 32,
  parameter int PRESC_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        IO_TMR_IRQ
);

  localparam logic [3:0] A_CTRL  = 4'd0;
  localparam logic [3:0] A_LOAD  = 4'd1;
  localparam logic [3:0] A_COUNT = 4'd2;
  localparam logic [3:0] A_STAT  = 4'd3;
  localparam logic [3:0] A_PRESC = 4'd4;

  logic [3:0]         addr_q;
  logic               write_q;
  logic               valid_q;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [COUNT_W-1:0] load_q, load_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               exp_q, exp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        hrdata_q, hrdata_d;
  logic [31:0]        rdata;
  logic               tick;
  logic               acc;
  logic               wr_en;
  logic               unused_bits;

  assign acc         = HSEL & HTRANS[1];
  assign wr_en       = valid_q & write_q;
  assign unused_bits = ^{HTRANS[0], HWDATA};

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    presc_d = presc_q;
    pcnt_d  = '0;
    tick    = 1'b0;

    if (ctrl_q[0]) begin
      tick   = (pcnt_q == presc_q);
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    if (wr_en && addr_q == A_PRESC) begin
      presc_d = HWDATA[PRESC_W-1:0];
      pcnt_d  = '0;
    end
    if (wr_en && addr_q == A_LOAD) load_d = HWDATA[COUNT_W-1:0];
    if (wr_en && addr_q == A_STAT && HWDATA[0]) exp_d = 1'b0;

    // A bus write to COUNT pre-empts both the decrement and the expiry of this tick.
    if (wr_en && addr_q == A_COUNT) begin
      count_d = HWDATA[COUNT_W-1:0];
    end else if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else begin
        exp_d = 1'b1;
        if (ctrl_q[1]) count_d = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    if (wr_en && addr_q == A_CTRL) ctrl_d = HWDATA[2:0];
  end

  // Reads see next-state values so a read right behind a write returns the new data.
  always_comb begin
    rdata = '0;
    case (HADDR)
      A_CTRL:  rdata = {29'b0, ctrl_d};
      A_LOAD:  rdata = 32'(load_d);
      A_COUNT: rdata = 32'(count_d);
      A_STAT:  rdata = {31'b0, exp_d};
      A_PRESC: rdata = 32'(presc_d);
      default: rdata = '0;
    endcase
    hrdata_d = (acc && !HWRITE) ? rdata : hrdata_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      load_q   <= '0;
      count_q  <= '0;
      exp_q    <= 1'b0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      hrdata_q <= '0;
    end else begin
      valid_q  <= acc;
      if (acc) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
      end
      ctrl_q   <= ctrl_d;
      load_q   <= load_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign HRDATA     = hrdata_q;
  assign IO_TMR_IRQ = exp_q & ctrl_q[2];

endmodule
